kim_pipe_hazard_ctrl: RTL and testbench

//  Central pipeline sequencer for the 5-stage MIPS core. Decides each cycle whether PC/IF_ID advance, stall or flush.

---
 rtl/kim_pipe_hazard_ctrl_pkg.sv | 67 ++++++
 rtl/kim_pipe_hazard_ctrl_sat_counter.sv | 26 ++
 rtl/kim_pipe_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_kim_pipe_hazard_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kim_pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states, priority reasons
// and the per-cycle control bundle with its decode helpers.
package kim_pipe_hazard_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_IMEM_WAIT = 2'd1,
    ST_DMEM_WAIT = 2'd2
  } ctrl_state_e;

  typedef enum logic [2:0] {
    PR_NONE     = 3'd0,
    PR_DMEM     = 3'd1,
    PR_REDIRECT = 3'd2,
    PR_LOAD_USE = 3'd3,
    PR_IMEM     = 3'd4
  } prio_e;

  typedef struct packed {
    logic pc_write_en;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_hold;
  } ctrl_t;

  // Front end squashed, back end idle while the core is held in reset
  localparam ctrl_t CTRL_RESET = '{pc_write_en: 1'b0, if_id_stall: 1'b0, if_id_flush: 1'b1,
                                   id_ex_bubble: 1'b1, ex_mem_hold: 1'b0};

  function automatic ctrl_t ctrl_for(input prio_e reason);
    ctrl_t c;
    c = '0;
    case (reason)
      PR_DMEM: begin
        c.if_id_stall = 1'b1;
        c.ex_mem_hold = 1'b1;
      end
      PR_REDIRECT: begin
        c.pc_write_en  = 1'b1;
        c.if_id_flush  = 1'b1;
        c.id_ex_bubble = 1'b1;
      end
      PR_LOAD_USE: begin
        c.if_id_stall  = 1'b1;
        c.id_ex_bubble = 1'b1;
      end
      PR_IMEM:  c.if_id_flush = 1'b1;
      PR_NONE:  c.pc_write_en = 1'b1;
      default:  c = CTRL_RESET;
    endcase
    return c;
  endfunction

  function automatic ctrl_state_e next_state_f(input prio_e reason);
    ctrl_state_e s;
    case (reason)
      PR_DMEM: s = ST_DMEM_WAIT;
      PR_IMEM: s = ST_IMEM_WAIT;
      default: s = ST_RUN;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/kim_pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset; sticks at all-ones.
module kim_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_r;

  // Count up on inc, holding once every bit is set
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != '1)) begin
      cnt_r <= cnt_r + WIDTH'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/kim_pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: same-cycle stall/flush/bubble
// decisions, a memory-wait FSM with timeout watchdog and saturating event counters.
module kim_pipe_hazard_ctrl
  import kim_pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = 16,
  parameter int MAX_WAIT   = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_branch_taken,
  input  logic                  ex_jump,
  input  logic                  imem_ready,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_write_en,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_hold,
  output logic [1:0]            ctrl_state,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic                  timeout_err
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT - 1);

  ctrl_state_e       state_r;
  ctrl_state_e       state_nxt_s;
  prio_e             reason_s;
  ctrl_t             ctrl_s;
  logic              load_use_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              timeout_err_r;

  // $zero is never a real producer, so a load targeting it cannot create a hazard
  assign load_use_s = ex_mem_read && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // Priority select: a data-memory wait freezes everything, so a branch in EX re-evaluates on release
  always_comb begin
    reason_s = PR_NONE;
    if (dmem_req && !dmem_ready) begin
      reason_s = PR_DMEM;
    end else if (ex_branch_taken || ex_jump) begin
      reason_s = PR_REDIRECT;
    end else if (load_use_s) begin
      reason_s = PR_LOAD_USE;
    end else if (!imem_ready) begin
      reason_s = PR_IMEM;
    end else begin
      reason_s = PR_NONE;
    end
  end

  // Control decode, overridden while reset is held low
  always_comb begin
    ctrl_s      = CTRL_RESET;
    state_nxt_s = next_state_f(reason_s);
    if (rstn) begin
      ctrl_s = ctrl_for(reason_s);
    end else begin
      ctrl_s = CTRL_RESET;
    end
  end

  assign pc_write_en  = ctrl_s.pc_write_en;
  assign if_id_stall  = ctrl_s.if_id_stall;
  assign if_id_flush  = ctrl_s.if_id_flush;
  assign id_ex_bubble = ctrl_s.id_ex_bubble;
  assign ex_mem_hold  = ctrl_s.ex_mem_hold;

  // Wait FSM and watchdog; the counter stops at the limit once the error is latched
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r       <= ST_RUN;
      wait_cnt_r    <= '0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r != ST_RUN) && (state_nxt_s == state_r)) begin
        if (wait_cnt_r == WAIT_LIM) begin
          timeout_err_r <= 1'b1;
        end else begin
          wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end
      end else begin
        wait_cnt_r <= '0;
      end
    end
  end

  assign ctrl_state  = state_r;
  assign timeout_err = timeout_err_r;

  kim_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (rstn && !ctrl_s.pc_write_en),
    .cnt  (stall_cnt)
  );

  kim_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (rstn && (reason_s == PR_REDIRECT)),
    .cnt  (flush_cnt)
  );

endmodule

// File: tb/tb_kim_pipe_hazard_ctrl.sv
// Directed self-checking bench for kim_pipe_hazard_ctrl (narrow counters, short watchdog).
module tb_kim_pipe_hazard_ctrl;

  localparam int RW = 5;
  localparam int CW = 4;
  localparam int MW = 8;
  localparam int SAT = (1 << CW) - 1;

  // {pc_write_en, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_hold}
  localparam logic [4:0] C_IDLE  = 5'b10000;
  localparam logic [4:0] C_LU    = 5'b01010;
  localparam logic [4:0] C_REDIR = 5'b10110;
  localparam logic [4:0] C_DMEM  = 5'b01001;
  localparam logic [4:0] C_IMEM  = 5'b00100;
  localparam logic [4:0] C_RST   = 5'b00110;

  logic          clk = 1'b0;
  logic          rstn;
  logic [RW-1:0] id_rs, id_rt, ex_rt;
  logic          id_uses_rt, ex_mem_read, ex_branch_taken, ex_jump;
  logic          imem_ready, dmem_req, dmem_ready;
  logic          pc_write_en, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_hold;
  logic [1:0]    ctrl_state;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic          timeout_err;
  logic [4:0]    ctl;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  assign ctl = {pc_write_en, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_hold};

  always #5 clk = ~clk;

  kim_pipe_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rstn(rstn), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .ex_jump(ex_jump), .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write_en(pc_write_en), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_mem_hold(ex_mem_hold), .ctrl_state(ctrl_state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .timeout_err(timeout_err)
  );

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_jump = 1'b0;
    imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle();
    #1;
    tests_run++;
    if (ctl !== C_RST) begin tests_failed++; $display("FAIL reset_ctl: got %b want %b", ctl, C_RST); end
    tick(); tick();
    tests_run++;
    if ({ctrl_state, stall_cnt, flush_cnt, timeout_err} !== {2'd0, 4'd0, 4'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_state: state=%0d stall=%0d flush=%0d to=%b want all 0",
               ctrl_state, stall_cnt, flush_cnt, timeout_err);
    end
    rstn = 1'b1;
    #1;
    tests_run++;
    if (ctl !== C_IDLE) begin tests_failed++; $display("FAIL idle_ctl: got %b want %b", ctl, C_IDLE); end
    tick();
    exp_stall = 0; exp_flush = 0;
    tests_run++;
    if (stall_cnt !== CW'(exp_stall)) begin tests_failed++; $display("FAIL idle_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_load_use();
    ex_mem_read = 1'b1; ex_rt = 5'd2; id_rs = 5'd2; id_rt = 5'd7; id_uses_rt = 1'b1;
    #1;
    tests_run++;
    if (ctl !== C_LU) begin tests_failed++; $display("FAIL lu_ctl: got %b want %b", ctl, C_LU); end
    tick(); exp_stall = sat_inc(exp_stall);
    ex_mem_read = 1'b0;
    #1;
    tests_run++;
    if ({ctl, stall_cnt} !== {C_IDLE, CW'(exp_stall)}) begin
      tests_failed++;
      $display("FAIL lu_release: ctl=%b stall=%0d want ctl=%b stall=%0d", ctl, stall_cnt, C_IDLE, exp_stall);
    end
    idle();
  endtask

  task automatic test_no_hazard_cases();
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    #1;
    tests_run++;
    if (ctl !== C_IDLE) begin tests_failed++; $display("FAIL zero_reg_ctl: got %b want %b", ctl, C_IDLE); end
    ex_rt = 5'd5; id_rt = 5'd5; id_rs = 5'd3; id_uses_rt = 1'b0;
    #1;
    tests_run++;
    if (ctl !== C_IDLE) begin tests_failed++; $display("FAIL rt_unused_ctl: got %b want %b", ctl, C_IDLE); end
    id_uses_rt = 1'b1;
    #1;
    tests_run++;
    if (ctl !== C_LU) begin tests_failed++; $display("FAIL rt_used_ctl: got %b want %b", ctl, C_LU); end
    tick(); exp_stall = sat_inc(exp_stall);
    idle();
    #1;
    tests_run++;
    if (stall_cnt !== CW'(exp_stall)) begin tests_failed++; $display("FAIL rt_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_redirect();
    ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
    #1;
    tests_run++;
    if (ctl !== C_REDIR) begin tests_failed++; $display("FAIL br_over_lu_ctl: got %b want %b", ctl, C_REDIR); end
    tick(); exp_flush = sat_inc(exp_flush);
    idle(); ex_jump = 1'b1; imem_ready = 1'b0;
    #1;
    tests_run++;
    if (ctl !== C_REDIR) begin tests_failed++; $display("FAIL jump_ctl: got %b want %b", ctl, C_REDIR); end
    tick(); exp_flush = sat_inc(exp_flush);
    idle();
    #1;
    tests_run++;
    if ({flush_cnt, stall_cnt, ctrl_state} !== {CW'(exp_flush), CW'(exp_stall), 2'd0}) begin
      tests_failed++;
      $display("FAIL redirect_cnts: flush=%0d stall=%0d state=%0d want %0d %0d 0",
               flush_cnt, stall_cnt, ctrl_state, exp_flush, exp_stall);
    end
  endtask

  task automatic test_dmem_wait_branch();
    dmem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (ctl !== C_DMEM) begin tests_failed++; $display("FAIL dmem_ctl[%0d]: got %b want %b", i, ctl, C_DMEM); end
      tick(); exp_stall = sat_inc(exp_stall);
      tests_run++;
      if (ctrl_state !== 2'd2) begin tests_failed++; $display("FAIL dmem_state[%0d]: got %0d want 2", i, ctrl_state); end
    end
    dmem_ready = 1'b1;
    #1;
    tests_run++;
    if (ctl !== C_REDIR) begin tests_failed++; $display("FAIL dmem_release_ctl: got %b want %b", ctl, C_REDIR); end
    tick(); exp_flush = sat_inc(exp_flush);
    idle();
    #1;
    tests_run++;
    if ({ctrl_state, flush_cnt, stall_cnt} !== {2'd0, CW'(exp_flush), CW'(exp_stall)}) begin
      tests_failed++;
      $display("FAIL dmem_after: state=%0d flush=%0d stall=%0d want 0 %0d %0d",
               ctrl_state, flush_cnt, stall_cnt, exp_flush, exp_stall);
    end
  endtask

  task automatic test_imem_timeout();
    imem_ready = 1'b0;
    #1;
    tests_run++;
    if (ctl !== C_IMEM) begin tests_failed++; $display("FAIL imem_ctl: got %b want %b", ctl, C_IMEM); end
    for (int i = 1; i <= MW + 1; i++) begin
      tick(); exp_stall = sat_inc(exp_stall);
      if (i == MW - 1) begin
        tests_run++;
        if ({ctrl_state, timeout_err} !== {2'd1, 1'b0}) begin
          tests_failed++;
          $display("FAIL imem_early: state=%0d to=%b want 1 0", ctrl_state, timeout_err);
        end
      end
    end
    tests_run++;
    if (timeout_err !== 1'b1) begin tests_failed++; $display("FAIL imem_timeout: got %b want 1", timeout_err); end
    imem_ready = 1'b1;
    #1;
    tests_run++;
    if (ctl !== C_IDLE) begin tests_failed++; $display("FAIL imem_release_ctl: got %b want %b", ctl, C_IDLE); end
    tick(); tick();
    tests_run++;
    if ({timeout_err, ctrl_state, stall_cnt} !== {1'b1, 2'd0, CW'(exp_stall)}) begin
      tests_failed++;
      $display("FAIL timeout_sticky: to=%b state=%0d stall=%0d want 1 0 %0d", timeout_err, ctrl_state, stall_cnt, exp_stall);
    end
  endtask

  task automatic test_reset_mid_dmem();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    tick(); tick();
    tests_run++;
    if (ctrl_state !== 2'd2) begin tests_failed++; $display("FAIL pre_reset_state: got %0d want 2", ctrl_state); end
    rstn = 1'b0;
    #1;
    tests_run++;
    if (ctl !== C_RST) begin tests_failed++; $display("FAIL mid_reset_ctl: got %b want %b", ctl, C_RST); end
    tick();
    tests_run++;
    if ({ctrl_state, stall_cnt, flush_cnt, timeout_err, if_id_flush} !== {2'd0, 4'd0, 4'd0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL mid_reset_state: state=%0d stall=%0d flush=%0d to=%b flush_o=%b want 0 0 0 0 1",
               ctrl_state, stall_cnt, flush_cnt, timeout_err, if_id_flush);
    end
    idle(); rstn = 1'b1;
    exp_stall = 0; exp_flush = 0;
    #1;
    tests_run++;
    if (ctl !== C_IDLE) begin tests_failed++; $display("FAIL post_reset_ctl: got %b want %b", ctl, C_IDLE); end
    tick();
  endtask

  task automatic test_saturation();
    ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
    for (int i = 1; i <= SAT + 1; i++) begin
      tick(); exp_stall = sat_inc(exp_stall);
      if (i >= SAT) begin
        tests_run++;
        if (stall_cnt !== CW'(exp_stall)) begin
          tests_failed++;
          $display("FAIL stall_sat[%0d]: got %0d want %0d", i, stall_cnt, exp_stall);
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard_cases();
    test_redirect();
    test_dmem_wait_branch();
    test_imem_timeout();
    test_reset_mid_dmem();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
